// File: rtl/iosys_pkg.sv
// iosys_pkg: shared port indices, FSM states and abort data for the iosys memory arbiter
package iosys_pkg;
  localparam logic [1:0] PORT_BOOT = 2'd0;
  localparam logic [1:0] PORT_CPU = 2'd1;
  localparam logic [1:0] PORT_DMA = 2'd2;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/iosys_arb_pick.sv
// iosys_arb_pick: boot-first winner selection with CPU/DMA round-robin
module iosys_arb_pick
  import iosys_pkg::*;
(
  input  logic [2:0] i_valid,
  input  logic [1:0] i_rr_last,
  output logic [1:0] o_win
);
  // boot always wins; a CPU/DMA tie goes to whichever was not served last
  always_comb
    o_win = i_valid[PORT_BOOT] ? PORT_BOOT :
            (i_valid[PORT_CPU] && i_valid[PORT_DMA]) ? ((i_rr_last == PORT_CPU) ? PORT_DMA : PORT_CPU) :
            i_valid[PORT_CPU] ? PORT_CPU : PORT_DMA;
endmodule

// File: rtl/iosys_mem_arbiter.sv
// iosys_mem_arbiter: serialises boot, CPU and DMA onto the single SDRAM port with a watchdog
module iosys_mem_arbiter #(
  parameter int AW = 23,
  parameter int TIMEOUT = 4096,
  parameter logic [31:0] TIMEOUT_RDATA = iosys_pkg::TIMEOUT_RDATA
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [2:0]      s_valid,
  input  logic [3*AW-1:0] s_addr,
  input  logic [95:0]     s_wdata,
  input  logic [11:0]     s_wstrb,
  output logic [2:0]      s_ready,
  output logic [31:0]     s_rdata,
  output logic            m_valid,
  output logic [AW-1:0]   m_addr,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  input  logic            m_ready,
  input  logic [31:0]     m_rdata,
  output logic [1:0]      grant,
  output logic            err,
  output logic [1:0]      err_port
);
  import iosys_pkg::*;
  localparam int CW = $clog2(TIMEOUT);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_rr_last, r_grant, r_err_port, w_win;
  logic r_m_valid, r_err, w_timeout;
  logic [AW-1:0] r_m_addr;
  logic [31:0] r_m_wdata, r_s_rdata;
  logic [3:0] r_m_wstrb;
  iosys_arb_pick u_pick (
    .i_valid  (s_valid),
    .i_rr_last(r_rr_last),
    .o_win    (w_win)
  );
  assign m_valid = r_m_valid;
  assign m_addr = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_wstrb = r_m_wstrb;
  assign s_rdata = r_s_rdata;
  assign grant = r_grant;
  assign err = r_err;
  assign err_port = r_err_port;
  // state register
  always_ff @(posedge clk)
    r_state <= !resetn ? IDLE : w_next;
  // next state; a completion in the last watchdog cycle still counts as a completion
  always_comb begin
    w_timeout = r_cnt == CW'(TIMEOUT - 1);
    w_next = r_state;
    s_ready = '0;
    if (r_state == IDLE)
      w_next = |s_valid ? BUSY : IDLE;
    else if (r_state == BUSY)
      w_next = (m_ready || w_timeout) ? RESP : BUSY;
    else begin
      w_next = IDLE;
      s_ready = 3'b001 << r_grant;
    end
  end
  // request latch, SDRAM handshake, watchdog and sticky error capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_m_valid <= 1'b0;
      r_m_addr <= '0;
      r_m_wdata <= '0;
      r_m_wstrb <= '0;
      r_s_rdata <= '0;
      r_grant <= PORT_BOOT;
      r_rr_last <= PORT_DMA;
      r_err <= 1'b0;
      r_err_port <= PORT_BOOT;
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (|s_valid) begin
        r_m_valid <= 1'b1;
        r_grant <= w_win;
        r_m_addr <= s_addr[w_win*AW +: AW];
        r_m_wdata <= s_wdata[w_win*32 +: 32];
        r_m_wstrb <= s_wstrb[w_win*4 +: 4];
        if (w_win != PORT_BOOT) r_rr_last <= w_win;
      end
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + 1'b1;
      if (m_ready) begin
        r_m_valid <= 1'b0;
        r_s_rdata <= m_rdata;
      end else if (w_timeout) begin
        r_m_valid <= 1'b0;
        r_s_rdata <= TIMEOUT_RDATA;
        r_err <= 1'b1;
        if (!r_err) r_err_port <= r_grant;
      end
    end else
      r_cnt <= '0;
  end
endmodule

// File: tb/tb_iosys_mem_arbiter.sv
// tb_iosys_mem_arbiter: randomized scenarios against a transaction-level arbitration model
module tb_iosys_mem_arbiter;
  localparam int AW = 23;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic resetn;
  logic [2:0] s_valid;
  logic [3*AW-1:0] s_addr;
  logic [95:0] s_wdata;
  logic [11:0] s_wstrb;
  logic [2:0] s_ready;
  logic [31:0] s_rdata;
  logic m_valid;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0] m_wstrb;
  logic m_ready;
  logic [31:0] m_rdata;
  logic [1:0] grant;
  logic err;
  logic [1:0] err_port;
  int errors = 0, checks = 0;
  logic [1:0] last;
  logic [AW-1:0] ea[3];
  logic [31:0] ed[3];
  logic [3:0] es[3];
  iosys_mem_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .m_valid(m_valid),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready),
    .m_rdata(m_rdata), .grant(grant), .err(err), .err_port(err_port)
  );
  always #5 clk = ~clk;
  // boot first, otherwise scan CPU/DMA starting after the last one served
  function automatic logic [1:0] model_pick(input logic [2:0] v, input logic [1:0] l);
    int p;
    if (v[0]) return 2'd0;
    for (int k = 1; k <= 2; k++) begin
      p = 1 + ((int'(l) + k - 1) % 2);
      if (v[p]) return 2'(p);
    end
    return 2'd0;
  endfunction
  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    s_addr[p*AW +: AW] = a;
    s_wdata[p*32 +: 32] = d;
    s_wstrb[p*4 +: 4] = s;
    ea[p] = a;
    ed[p] = d;
    es[p] = s;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    s_valid = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    last = 2'd2;
  endtask
  task automatic serve(input int lat, input logic [31:0] d, output int w, output logic [1:0] g,
                       output logic [AW-1:0] a, output logic [31:0] wd, output logic [3:0] ws,
                       output logic [2:0] rdy, output logic [31:0] rd);
    w = 0;
    rdy = '0;
    rd = '0;
    do begin
      @(negedge clk);
      w++;
    end while (!m_valid && w < 40);
    g = grant;
    a = m_addr;
    wd = m_wdata;
    ws = m_wstrb;
    if (!m_valid) return;
    repeat (lat) @(negedge clk);
    m_ready = 1'b1;
    m_rdata = d;
    @(negedge clk);
    m_ready = 1'b0;
    m_rdata = $urandom;
    rdy = s_ready;
    rd = s_rdata;
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL reset_s_ready: got %b want 000", s_ready); end
    checks++; if (s_rdata !== 32'h0) begin errors++; $display("FAIL reset_s_rdata: got %h want 0", s_rdata); end
    checks++; if ({m_addr, m_wdata, m_wstrb} !== '0) begin errors++; $display("FAIL reset_m_bus: got %h/%h/%h want 0", m_addr, m_wdata, m_wstrb); end
    checks++; if ({grant, err, err_port} !== 5'b0) begin errors++; $display("FAIL reset_status: got g=%0d e=%b ep=%0d want 0", grant, err, err_port); end
    do_reset();
  endtask
  task automatic test_single_read();
    int w; logic [1:0] g; logic [AW-1:0] a; logic [31:0] wd, rd; logic [3:0] ws; logic [2:0] rdy;
    set_port(1, 23'h000100, 32'h0, 4'h0);
    s_valid = 3'b010;
    serve(5, 32'h12345678, w, g, a, wd, ws, rdy, rd);
    checks++; if (w !== 1) begin errors++; $display("FAIL single_latency: got %0d want 1", w); end
    checks++; if (g !== 2'd1 || a !== 23'h000100) begin errors++; $display("FAIL single_grant: got g=%0d a=%h want 1/000100", g, a); end
    checks++; if (rdy !== 3'b010 || rd !== 32'h12345678) begin errors++; $display("FAIL single_resp: got %b/%h want 010/12345678", rdy, rd); end
    s_valid = 3'b000;
    last = 2'd1;
    @(negedge clk);
    checks++; if (s_ready !== 3'b000 || m_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b/%b want 000/0", s_ready, m_valid); end
  endtask
  task automatic test_boot_priority();
    int w; logic [1:0] g; logic [AW-1:0] a; logic [31:0] wd, rd; logic [3:0] ws; logic [2:0] rdy;
    set_port(0, 23'h000040, 32'hAAAAAAAA, 4'b0100);
    set_port(1, 23'h000200, $urandom, 4'h0);
    s_valid = 3'b011;
    serve(2, 32'h0BADF00D, w, g, a, wd, ws, rdy, rd);
    checks++; if (g !== 2'd0 || a !== 23'h000040) begin errors++; $display("FAIL boot_first: got g=%0d a=%h want 0/000040", g, a); end
    checks++; if (ws !== 4'b0100 || wd !== 32'hAAAAAAAA) begin errors++; $display("FAIL boot_write: got %b/%h want 0100/aaaaaaaa", ws, wd); end
    checks++; if (rdy !== 3'b001 || rd !== 32'h0BADF00D) begin errors++; $display("FAIL boot_resp: got %b/%h want 001/0badf00d", rdy, rd); end
    s_valid = 3'b010;
    serve(3, 32'hCAFE0001, w, g, a, wd, ws, rdy, rd);
    checks++; if (w !== 2) begin errors++; $display("FAIL back_to_back_gap: got %0d want 2", w); end
    checks++; if (g !== 2'd1 || a !== 23'h000200 || rdy !== 3'b010 || rd !== 32'hCAFE0001) begin errors++; $display("FAIL boot_then_cpu: got g=%0d a=%h %b/%h", g, a, rdy, rd); end
    s_valid = 3'b000;
    last = 2'd1;
  endtask
  task automatic test_round_robin();
    int w; logic [1:0] g, e; logic [AW-1:0] a; logic [31:0] wd, rd, d; logic [3:0] ws; logic [2:0] rdy;
    do_reset();
    set_port(1, AW'($urandom), $urandom, 4'h0);
    set_port(2, AW'($urandom), $urandom, 4'h0);
    s_valid = 3'b110;
    for (int i = 0; i < 6; i++) begin
      e = (i % 2 == 0) ? 2'd1 : 2'd2;
      d = $urandom;
      serve($urandom_range(0, 4), d, w, g, a, wd, ws, rdy, rd);
      checks++; if (g !== e || a !== ea[e]) begin errors++; $display("FAIL rr_grant%0d: got g=%0d a=%h want %0d/%h", i, g, a, e, ea[e]); end
      checks++; if (rdy !== (3'b001 << e) || rd !== d) begin errors++; $display("FAIL rr_resp%0d: got %b/%h want %b/%h", i, rdy, rd, 3'b001 << e, d); end
      set_port(int'(e), AW'($urandom), $urandom, 4'h0);
    end
    s_valid = 3'b000;
    last = 2'd2;
  endtask
  task automatic test_random();
    int w; logic [1:0] g, e; logic [AW-1:0] a; logic [31:0] wd, rd, d; logic [3:0] ws; logic [2:0] rdy, pend;
    pend = '0;
    for (int i = 0; i < 14; i++) begin
      for (int p = 0; p < 3; p++)
        if (!pend[p] && (p == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 1) == 1)) begin
          set_port(p, AW'($urandom), $urandom, 4'($urandom));
          pend[p] = 1'b1;
        end
      if (pend == 3'b000) begin
        set_port(2, AW'($urandom), $urandom, 4'($urandom));
        pend[2] = 1'b1;
      end
      s_valid = pend;
      e = model_pick(pend, last);
      d = $urandom;
      serve($urandom_range(0, 6), d, w, g, a, wd, ws, rdy, rd);
      checks++; if (g !== e) begin errors++; $display("FAIL rand_grant%0d: got %0d want %0d (pend %b)", i, g, e, pend); end
      checks++; if (a !== ea[e] || wd !== ed[e] || ws !== es[e]) begin errors++; $display("FAIL rand_bus%0d: got %h/%h/%h want %h/%h/%h", i, a, wd, ws, ea[e], ed[e], es[e]); end
      checks++; if (rdy !== (3'b001 << e) || rd !== d) begin errors++; $display("FAIL rand_resp%0d: got %b/%h want %b/%h", i, rdy, rd, 3'b001 << e, d); end
      if (e != 2'd0) last = e;
      pend[e] = 1'b0;
      s_valid = pend;
    end
    s_valid = 3'b000;
    @(negedge clk);
  endtask
  task automatic test_timeout();
    int n, w; logic [1:0] g; logic [AW-1:0] a; logic [31:0] wd, rd; logic [3:0] ws; logic [2:0] rdy;
    set_port(2, 23'h7FFF00, 32'h0, 4'h0);
    s_valid = 3'b100;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 40);
    n = 0;
    while (m_valid && n < TO + 4) begin n++; @(negedge clk); end
    checks++; if (n !== TO) begin errors++; $display("FAIL timeout_busy_len: got %0d want %0d", n, TO); end
    checks++; if (s_ready !== 3'b100 || s_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_resp: got %b/%h want 100/deadbeef", s_ready, s_rdata); end
    checks++; if (err !== 1'b1 || err_port !== 2'd2) begin errors++; $display("FAIL timeout_err: got %b/%0d want 1/2", err, err_port); end
    s_valid = 3'b000;
    last = 2'd2;
    set_port(1, 23'h000444, 32'h0, 4'h0);
    s_valid = 3'b010;
    serve(2, 32'h13579BDF, w, g, a, wd, ws, rdy, rd);
    checks++; if (rdy !== 3'b010 || rd !== 32'h13579BDF) begin errors++; $display("FAIL after_timeout_resp: got %b/%h want 010/13579bdf", rdy, rd); end
    checks++; if (err !== 1'b1 || err_port !== 2'd2) begin errors++; $display("FAIL err_sticky: got %b/%0d want 1/2", err, err_port); end
    s_valid = 3'b000;
    @(negedge clk);
    s_valid = 3'b010;
    n = 0;
    do begin @(negedge clk); n++; end while (s_ready == 3'b000 && n < TO + 10);
    checks++; if (s_ready !== 3'b010 || s_rdata !== 32'hDEADBEEF || err_port !== 2'd2) begin errors++; $display("FAIL second_timeout: got %b/%h/%0d want 010/deadbeef/2", s_ready, s_rdata, err_port); end
    s_valid = 3'b000;
    last = 2'd1;
  endtask
  task automatic test_reset_mid();
    int n;
    set_port(1, 23'h000321, 32'h0, 4'h0);
    s_valid = 3'b010;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 40);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b want 1", m_valid); end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    s_valid = 3'b000;
    last = 2'd2;
    checks++; if (m_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midreset_drop: got m_valid=%b err=%b want 0/0", m_valid, err); end
    m_ready = 1'b1;
    m_rdata = $urandom;
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL late_ready: got %b want 000", s_ready); end
    @(negedge clk);
    checks++; if (s_ready !== 3'b000 || m_valid !== 1'b0) begin errors++; $display("FAIL late_ready_idle: got %b/%b want 000/0", s_ready, m_valid); end
    set_port(2, 23'h000654, 32'h0, 4'h0);
    s_valid = 3'b100;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || grant !== 2'd2 || m_addr !== 23'h000654) begin errors++; $display("FAIL post_reset_grant: got %b/%0d/%h want 1/2/000654", m_valid, grant, m_addr); end
    m_ready = 1'b1;
    m_rdata = 32'h600DD00D;
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if (s_ready !== 3'b100 || s_rdata !== 32'h600DD00D) begin errors++; $display("FAIL post_reset_resp: got %b/%h want 100/600dd00d", s_ready, s_rdata); end
    s_valid = 3'b000;
  endtask
  task automatic test_timeout_race();
    int w; logic [1:0] g; logic [AW-1:0] a; logic [31:0] wd, rd; logic [3:0] ws; logic [2:0] rdy;
    set_port(1, 23'h000888, 32'h0, 4'h0);
    s_valid = 3'b010;
    serve(TO - 1, 32'h5A5A1234, w, g, a, wd, ws, rdy, rd);
    checks++; if (rdy !== 3'b010 || rd !== 32'h5A5A1234) begin errors++; $display("FAIL race_resp: got %b/%h want 010/5a5a1234", rdy, rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL race_err: got %b want 0", err); end
    s_valid = 3'b000;
  endtask
  initial begin
    resetn = 1'b0;
    s_valid = '0;
    s_addr = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_ready = 1'b0;
    m_rdata = '0;
    last = 2'd2;
    test_reset();
    test_single_read();
    test_boot_priority();
    test_round_robin();
    test_random();
    test_timeout();
    test_reset_mid();
    test_timeout_race();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/iosys_mem_arbiter.md
Name: iosys_mem_arbiter

Overview:
- Shares the single 32-bit, 8MB iosys memory port to SDRAM between three requesters: the boot flash loader (port 0), the PicoRV32 core (port 1) and a future savestate/DMA engine (port 2).
- Sits between the requesters and the rv_valid/rv_ready interface.
- Serialises the requesters into one outstanding transaction at a time, with fixed priority for boot and round-robin between CPU and DMA.
- A watchdog keeps a hung SDRAM access from wedging the menu system.

Parameters:
- AW, 23, address width in bytes (8MB space).
- TIMEOUT, 4096, clk cycles in BUSY without m_ready before the access is aborted; minimum 4.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on an aborted access.

Ports:
- clk  in  1  iosys clock
- resetn  in  1  reset; synchronous, active-low
- s_valid  in  3  per-port request; held until that port's s_ready; bit0=boot, bit1=cpu, bit2=dma
- s_addr  in  3*AW  per-port byte address, port n at [n*AW +: AW]
- s_wdata  in  96  per-port write data, 32 bits per port
- s_wstrb  in  12  per-port byte strobes, 4 per port; 0 = read
- s_ready  out  3  one-cycle completion pulse to the granted port
- s_rdata  out  32  read data, valid while any s_ready bit is high
- m_valid  out  1  to SDRAM (rv_valid)
- m_addr  out  AW  to SDRAM
- m_wdata  out  32  to SDRAM
- m_wstrb  out  4  to SDRAM
- m_ready  in  1  one-cycle pulse from SDRAM when the access is done
- m_rdata  in  32  SDRAM read data, valid with m_ready
- grant  out  2  current/last granted port index (debug)
- err  out  1  sticky: a timeout has occurred
- err_port  out  2  port of the first timed-out access

Behaviour:
- Reset values: s_ready=0, s_rdata=0, m_valid=0, m_addr/m_wdata/m_wstrb=0, grant=0, err=0, err_port=0, rr_last=2 (so the first CPU/DMA tie goes to the CPU). State=IDLE, timeout counter=0.
- Reset asserted mid-transaction: m_valid drops at the next edge. A late m_ready arriving after that is ignored.
- FSM, IDLE:
  - If any s_valid bit is set, select a winner and latch its addr/wdata/wstrb into the m_* registers.
  - Set m_valid=1 and grant=winner, go to BUSY.
  - Latency: s_valid at cycle N gives m_valid at cycle N+1.
- Arbitration:
  - Port 0 wins whenever s_valid[0]=1.
  - Otherwise, if ports 1 and 2 both request, grant the one not equal to rr_last.
  - Otherwise grant the single requester.
  - rr_last updates only when port 1 or 2 is granted.
- FSM, BUSY:
  - m_* outputs are stable and m_valid stays 1.
  - Timeout counter increments each cycle.
  - Requester inputs are ignored, including a change to the granted port's fields.
  - On m_ready: m_valid=0, s_rdata<=m_rdata (for writes as well), go to RESP.
  - On counter==TIMEOUT-1 without m_ready: m_valid=0, s_rdata<=TIMEOUT_RDATA, err<=1 (err_port latched only if err was 0), go to RESP.
  - If m_ready arrives in the same cycle as the timeout, m_ready wins: no error, real data returned.
- FSM, RESP:
  - s_ready[grant]=1 for exactly one cycle; counter cleared; go to IDLE.
  - The requester drops s_valid the cycle after seeing s_ready, so IDLE never re-grants a stale request.
- Back-to-back rate: at most one transaction per 3 + SDRAM-latency cycles.
- A port's s_valid dropping while it is granted is not legal; the arbiter still completes the access.
- err clears only on reset.
- m_ready seen in IDLE or RESP is ignored.

Decomposition:
- Shared package iosys_pkg holds:
  - port index constants PORT_BOOT=0, PORT_CPU=1, PORT_DMA=2
  - the FSM state encoding IDLE/BUSY/RESP
  - TIMEOUT_RDATA
- One natural sub-module: iosys_arb_pick, the combinational winner selection (priority plus round-robin), instantiated once. Everything else stays in the top level.

Test Plan:
- Single CPU read at addr 0x000100, m_ready pulsed 5 cycles after m_valid with m_rdata=0x12345678 -> m_valid rises 1 cycle after s_valid; s_ready[1] pulses once 1 cycle after m_ready with s_rdata=0x12345678.
- Boot write (wstrb=4'b0100, wdata=0xAAAAAAAA) and CPU read both raised in the same cycle -> port 0 granted first, m_wstrb=4'b0100; CPU served next with no gap beyond the IDLE cycle.
- CPU and DMA held continuously for 6 transactions -> grants alternate 1,2,1,2,1,2.
- No m_ready for TIMEOUT cycles on a DMA read -> m_valid drops at cycle TIMEOUT; s_ready[2] pulses with s_rdata=0xDEADBEEF; err=1, err_port=2. A later CPU access completes normally and err stays 1.
- resetn low during BUSY, then m_ready pulse after release -> m_valid=0 the cycle after reset, no s_ready pulse, state IDLE.
- m_ready in exactly the timeout cycle -> data returned, err stays 0.
